// File: rtl/calib_sched.sv
// calib_sched: shares one calibration datapath round-robin across NUM_CH channels.
// Optional feature macro CALIB_TIMEOUT_EN: EEPROM read timeout with sticky cal_err.
module calib_sched #(
  parameter int         NUM_CH   = 3,
  parameter logic [7:0] EEP_BASE = 8'h00,
  parameter int         TMO_CYC  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cal_start,
  output logic [7:0]          eep_addr,
  output logic                eep_rd,
  input  logic [7:0]          eep_rdata,
  input  logic                eep_rdy,
  input  logic [NUM_CH-1:0]   ch_vld,
  input  logic [8*NUM_CH-1:0] ch_raw,
  output logic [NUM_CH-1:0]   ch_ack,
  output logic [7:0]          dp_raw,
  output logic [7:0]          dp_off,
  output logic [7:0]          dp_gain,
  input  logic [7:0]          dp_corr,
  output logic                out_vld,
  output logic [1:0]          out_ch,
  output logic [7:0]          out_data,
  output logic                cal_busy,
  output logic                cal_err
);

  typedef enum logic [1:0] {
    LOAD_REQ,
    LOAD_WAIT,
    RUN
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(2*NUM_CH-1);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [8*NUM_CH-1:0] off_q, off_d;
  logic [8*NUM_CH-1:0] gain_q, gain_d;
  logic [1:0]          ptr_q, ptr_d;
  logic                eep_rd_q, eep_rd_d;
  logic [7:0]          eep_addr_q, eep_addr_d;
  logic                busy_q, busy_d;
  logic                out_vld_q, out_vld_d;
  logic [1:0]          out_ch_q, out_ch_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [7:0]          dp_raw_q, dp_raw_d;
  logic [7:0]          dp_off_q, dp_off_d;
  logic [7:0]          dp_gain_q, dp_gain_d;
  logic [NUM_CH-1:0]   ack_c;
  logic                any_req;
  logic [1:0]          win;
  logic [NUM_CH-1:0]   vld_sh;
  logic [8*NUM_CH-1:0] raw_sh, off_sh, gain_sh;
  logic                wr_en;
  logic [7:0]          wr_data;
`ifdef CALIB_TIMEOUT_EN
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
`else
  logic                unused_tmo;
  assign unused_tmo = (TMO_CYC == 0);
`endif

  // First requester strictly after the last winner, wrapping.
  always_comb begin
    int c;
    any_req = 1'b0;
    win     = ptr_q;
    vld_sh  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      vld_sh = ch_vld >> c;
      if (!any_req && vld_sh[0]) begin
        any_req = 1'b1;
        win     = 2'(c);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    off_d      = off_q;
    gain_d     = gain_q;
    ptr_d      = ptr_q;
    eep_rd_d   = 1'b0;
    eep_addr_d = eep_addr_q;
    busy_d     = busy_q;
    out_vld_d  = 1'b0;
    out_ch_d   = out_ch_q;
    out_data_d = out_data_q;
    dp_raw_d   = dp_raw_q;
    dp_off_d   = dp_off_q;
    dp_gain_d  = dp_gain_q;
    ack_c      = '0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
`ifdef CALIB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    raw_sh     = ch_raw >> (8*int'(win));
    off_sh     = off_q >> (8*int'(win));
    gain_sh    = gain_q >> (8*int'(win));
    unique case (state_q)
      LOAD_REQ: begin
        eep_addr_d = EEP_BASE + {5'd0, idx_q};
        eep_rd_d   = 1'b1;
        state_d    = LOAD_WAIT;
`ifdef CALIB_TIMEOUT_EN
        cnt_d      = 8'd0;
`endif
      end
      LOAD_WAIT: begin
        if (eep_rdy) begin
          wr_en   = 1'b1;
          wr_data = eep_rdata;
        end
`ifdef CALIB_TIMEOUT_EN
        else if (cnt_q == 8'(TMO_CYC-1)) begin
          wr_en   = 1'b1;
          wr_data = idx_q[0] ? 8'h80 : 8'h00;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
        if (wr_en) begin
          if (idx_q == LAST_IDX) begin
            state_d = RUN;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD_REQ;
          end
        end
      end
      RUN: begin
        if (cal_start) begin
          state_d = LOAD_REQ;
          idx_d   = 3'd0;
          busy_d  = 1'b1;
`ifdef CALIB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else if (any_req) begin
          ack_c      = ONE << win;
          ptr_d      = win;
          dp_raw_d   = raw_sh[7:0];
          dp_off_d   = off_sh[7:0];
          dp_gain_d  = gain_sh[7:0];
          out_vld_d  = 1'b1;
          out_ch_d   = win;
          out_data_d = dp_corr;
        end
      end
      default: state_d = LOAD_REQ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en && idx_q[2:1] == 2'(c)) begin
        if (idx_q[0]) gain_d[8*c +: 8] = wr_data;
        else          off_d[8*c +: 8]  = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD_REQ;
      idx_q      <= 3'd0;
      off_q      <= '0;
      gain_q     <= {NUM_CH{8'h80}};
      ptr_q      <= 2'(NUM_CH-1);
      eep_rd_q   <= 1'b0;
      eep_addr_q <= 8'h00;
      busy_q     <= 1'b1;
      out_vld_q  <= 1'b0;
      out_ch_q   <= 2'd0;
      out_data_q <= 8'h00;
      dp_raw_q   <= 8'h00;
      dp_off_q   <= 8'h00;
      dp_gain_q  <= 8'h00;
`ifdef CALIB_TIMEOUT_EN
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      off_q      <= off_d;
      gain_q     <= gain_d;
      ptr_q      <= ptr_d;
      eep_rd_q   <= eep_rd_d;
      eep_addr_q <= eep_addr_d;
      busy_q     <= busy_d;
      out_vld_q  <= out_vld_d;
      out_ch_q   <= out_ch_d;
      out_data_q <= out_data_d;
      dp_raw_q   <= dp_raw_d;
      dp_off_q   <= dp_off_d;
      dp_gain_q  <= dp_gain_d;
`ifdef CALIB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign eep_addr = eep_addr_q;
  assign eep_rd   = eep_rd_q;
  assign ch_ack   = ack_c;
  assign dp_raw   = dp_raw_d;
  assign dp_off   = dp_off_d;
  assign dp_gain  = dp_gain_d;
  assign out_vld  = out_vld_q;
  assign out_ch   = out_ch_q;
  assign out_data = out_data_q;
  assign cal_busy = busy_q;
`ifdef CALIB_TIMEOUT_EN
  assign cal_err  = err_q;
`else
  assign cal_err  = 1'b0;
`endif

endmodule

// File: tb/tb_calib_sched.sv
// tb_calib_sched: random and directed checks of calib_sched against a queue-based model.
// Exercises the CALIB_TIMEOUT_EN path only when that macro is defined.
module tb_calib_sched;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst, cal_start;
  logic [7:0] eep_addr, eep_rdata;
  logic eep_rd, eep_rdy;
  logic [N-1:0] ch_vld, ch_ack;
  logic [8*N-1:0] ch_raw;
  logic [7:0] dp_raw, dp_off, dp_gain, dp_corr;
  logic out_vld;
  logic [1:0] out_ch;
  logic [7:0] out_data;
  logic cal_busy, cal_err;

  int checks = 0;
  int failures = 0;

  calib_sched #(.NUM_CH(N), .EEP_BASE(8'h00), .TMO_CYC(255)) dut (
    .clk(clk), .rst(rst), .cal_start(cal_start),
    .eep_addr(eep_addr), .eep_rd(eep_rd),
    .eep_rdata(eep_rdata), .eep_rdy(eep_rdy),
    .ch_vld(ch_vld), .ch_raw(ch_raw), .ch_ack(ch_ack),
    .dp_raw(dp_raw), .dp_off(dp_off), .dp_gain(dp_gain),
    .dp_corr(dp_corr), .out_vld(out_vld), .out_ch(out_ch),
    .out_data(out_data), .cal_busy(cal_busy), .cal_err(cal_err)
  );

  always #5 clk = ~clk;

  // corrected = sat(gain*(raw+off))>>7, raw/gain unsigned, off signed
  function automatic logic [7:0] calib(logic [7:0] r, logic [7:0] o,
                                       logic [7:0] g);
    int p;
    p = int'(g) * (int'(r) + int'($signed(o)));
    if (p < 0) return 8'h00;
    p = p / 128;
    if (p > 255) return 8'hFF;
    return 8'(p);
  endfunction

  assign dp_corr = calib(dp_raw, dp_off, dp_gain);

  logic [7:0] mem [256];
  logic [7:0] m_off [N];
  logic [7:0] m_gain [N];
  int order [$];

  function automatic void model_reset();
    order = {};
    for (int c = 0; c < N; c++) order.push_back(c);
  endfunction

  function automatic int model_pick(logic [N-1:0] req);
    logic [N-1:0] s;
    foreach (order[i]) begin
      s = req >> order[i];
      if (s[0]) return order[i];
    end
    return -1;
  endfunction

  function automatic void model_grant(int w);
    while (order[order.size()-1] != w) order.push_back(order.pop_front());
  endfunction

  function automatic void model_load(int drop);
    for (int c = 0; c < N; c++) begin
      m_off[c]  = (2*c == drop) ? 8'h00 : mem[2*c];
      m_gain[c] = (2*c+1 == drop) ? 8'h80 : mem[2*c+1];
    end
  endfunction

  // EEPROM responder
  int eep_lat = 2;
  int eep_drop = -1;
  int pend = 0;
  logic [7:0] pend_addr;
  int cyc_n = 0;
  int rdy_cnt = 0;
  int last_rdy_cyc = 0;
  logic [7:0] rd_addrs [$];
  int rd_cyc [$];

  always @(posedge clk) begin
    #1;
    cyc_n++;
    eep_rdy = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          eep_rdy = 1'b1;
          eep_rdata = mem[pend_addr];
          rdy_cnt++;
          last_rdy_cyc = cyc_n;
        end
      end
      if (eep_rd) begin
        rd_addrs.push_back(eep_addr);
        rd_cyc.push_back(cyc_n);
        if (int'(eep_addr) != eep_drop) begin
          pend = eep_lat;
          pend_addr = eep_addr;
        end
      end
    end
  end

  logic [N-1:0] o_ack;
  logic [7:0] o_raw, o_off, o_gain, o_data;
  logic o_vld0, o_vld;
  logic [1:0] o_ch;

  task automatic step(input logic [N-1:0] v, input logic [8*N-1:0] r,
                      input logic cs);
    ch_vld = v;
    ch_raw = r;
    cal_start = cs;
    #1;
    o_ack = ch_ack;
    o_raw = dp_raw;
    o_off = dp_off;
    o_gain = dp_gain;
    o_vld0 = out_vld;
    @(posedge clk);
    #2;
    o_vld = out_vld;
    o_ch = out_ch;
    o_data = out_data;
    cal_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_load(output int cyc, output bit ack_seen);
    cyc = 0;
    ack_seen = 0;
    while (cal_busy === 1'b1 && cyc < 3000) begin
      if (ch_ack !== '0) ack_seen = 1;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cal_start = 1'b0;
    ch_vld = '0;
    ch_raw = '0;
    repeat (3) @(negedge clk);
    model_reset();
    for (int c = 0; c < N; c++) begin
      m_off[c] = 8'h00;
      m_gain[c] = 8'h80;
    end
    checks++;
    if ({eep_rd, eep_addr, ch_ack, cal_busy, cal_err} !== {1'b0, 8'h00, 3'b000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_ctl got rd=%b addr=%h ack=%b busy=%b err=%b", eep_rd, eep_addr, ch_ack, cal_busy, cal_err);
    end
    checks++;
    if ({out_vld, out_ch, out_data, dp_raw, dp_off, dp_gain} !== 35'd0) begin
      failures++;
      $display("FAIL reset_out got vld=%b ch=%0d data=%h dp=%h/%h/%h exp all 0", out_vld, out_ch, out_data, dp_raw, dp_off, dp_gain);
    end
  endtask

  task automatic test_load();
    int cyc;
    bit ack_seen;
    logic [7:0] tbl [6] = '{8'h10, 8'h80, 8'hF0, 8'h40, 8'h00, 8'hFF};
    for (int i = 0; i < 6; i++) mem[i] = tbl[i];
    rd_addrs.delete();
    rdy_cnt = 0;
    ch_vld = 3'b111;
    rst = 1'b0;
    wait_load(cyc, ack_seen);
    ch_vld = '0;
    checks++;
    if (cal_busy !== 1'b0 || ack_seen) begin
      failures++;
      $display("FAIL load_done busy=%b ack_seen=%0d cyc=%0d exp busy=0 no ack", cal_busy, ack_seen, cyc);
    end
    checks++;
    if (rd_addrs.size() != 6 || rdy_cnt != 6) begin
      failures++;
      $display("FAIL load_reads got rd=%0d rdy=%0d exp 6/6", rd_addrs.size(), rdy_cnt);
    end
    foreach (rd_addrs[i]) begin
      checks++;
      if (rd_addrs[i] !== 8'(i)) begin
        failures++;
        $display("FAIL load_addr%0d got %h exp %h", i, rd_addrs[i], 8'(i));
      end
    end
    checks++;
    if (cyc_n != last_rdy_cyc + 1 || cal_err !== 1'b0) begin
      failures++;
      $display("FAIL busy_fall got cyc=%0d err=%b exp cyc=%0d err=0", cyc_n, cal_err, last_rdy_cyc + 1);
    end
    model_load(-1);
  endtask

  task automatic test_directed();
    step(3'b001, {8'h80, 8'h00, 8'h40}, 1'b0);
    checks++;
    if ({o_ack, o_raw, o_off, o_gain} !== {3'b001, 8'h40, 8'h10, 8'h80}) begin
      failures++;
      $display("FAIL dir_ch0_dp got ack=%b dp=%h/%h/%h exp 001 40/10/80", o_ack, o_raw, o_off, o_gain);
    end
    checks++;
    if ({o_vld, o_ch, o_data} !== {1'b1, 2'd0, 8'h50}) begin
      failures++;
      $display("FAIL dir_ch0_out got vld=%b ch=%0d data=%h exp 1 0 50", o_vld, o_ch, o_data);
    end
    model_grant(0);
    step(3'b100, {8'h80, 8'h00, 8'h40}, 1'b0);
    checks++;
    if ({o_ack, o_vld, o_ch, o_data} !== {3'b100, 1'b1, 2'd2, 8'hFF}) begin
      failures++;
      $display("FAIL dir_ch2 got ack=%b vld=%b ch=%0d data=%h exp 100 1 2 FF", o_ack, o_vld, o_ch, o_data);
    end
    model_grant(2);
    step(3'b000, {8'h11, 8'h22, 8'h33}, 1'b0);
    checks++;
    if ({o_ack, o_raw, o_off, o_gain, o_vld, o_ch, o_data} !== {3'b000, 8'h80, 8'h00, 8'hFF, 1'b0, 2'd2, 8'hFF}) begin
      failures++;
      $display("FAIL dir_idle got ack=%b dp=%h/%h/%h vld=%b ch=%0d data=%h exp hold", o_ack, o_raw, o_off, o_gain, o_vld, o_ch, o_data);
    end
  endtask

  task automatic test_rotate();
    logic [N-1:0] exp_ack;
    logic [8*N-1:0] r;
    logic [7:0] exp_d;
    for (int i = 0; i < 6; i++) begin
      r = 24'($urandom);
      exp_ack = 3'b001 << (i % 3);
      exp_d = calib(r[8*(i%3) +: 8], m_off[i%3], m_gain[i%3]);
      step(3'b111, r, 1'b0);
      checks++;
      if (o_ack !== exp_ack || o_vld !== 1'b1 || o_ch !== 2'(i % 3) || o_data !== exp_d) begin
        failures++;
        $display("FAIL rotate%0d got ack=%b vld=%b ch=%0d data=%h exp %b 1 %0d %h", i, o_ack, o_vld, o_ch, o_data, exp_ack, i % 3, exp_d);
      end
      model_grant(i % 3);
    end
  endtask

  task automatic test_cal_start();
    int cyc, w;
    bit ack_seen;
    logic [8*N-1:0] r;
    logic [7:0] exp_d;
    step(3'b111, 24'h010203, 1'b0);
    model_grant(0);
    for (int i = 0; i < 2*N; i++) mem[i] = 8'($urandom);
    rd_addrs.delete();
    step(3'b111, 24'h010203, 1'b1);
    checks++;
    if (o_ack !== 3'b000 || o_vld0 !== 1'b1 || o_vld !== 1'b0) begin
      failures++;
      $display("FAIL cal_start got ack=%b vld_in=%b vld_after=%b exp 000 1 0", o_ack, o_vld0, o_vld);
    end
    wait_load(cyc, ack_seen);
    checks++;
    if (cal_busy !== 1'b0 || ack_seen || rd_addrs.size() != 6) begin
      failures++;
      $display("FAIL reload got busy=%b ack_seen=%0d reads=%0d exp 0 0 6", cal_busy, ack_seen, rd_addrs.size());
    end
    model_load(-1);
    for (int i = 0; i < 3; i++) begin
      r = 24'($urandom);
      w = model_pick(3'b111);
      exp_d = calib(r[8*w +: 8], m_off[w], m_gain[w]);
      step(3'b111, r, 1'b0);
      checks++;
      if (o_ack !== (3'b001 << w) || o_ch !== 2'(w) || o_data !== exp_d || (i == 0 && w != 1)) begin
        failures++;
        $display("FAIL resume%0d got ack=%b ch=%0d data=%h exp ch=%0d data=%h", i, o_ack, o_ch, o_data, w, exp_d);
      end
      model_grant(w);
    end
  endtask

  task automatic test_rst_mid_load();
    int n, cyc;
    bit ack_seen;
    for (int i = 0; i < 2*N; i++) mem[i] = 8'($urandom);
    rd_addrs.delete();
    step(3'b000, 24'h0, 1'b1);
    n = 0;
    while (rd_addrs.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (eep_rd !== 1'b0 || cal_busy !== 1'b1 || dp_raw !== 8'h00 || out_vld !== 1'b0 || n >= 200) begin
      failures++;
      $display("FAIL rst_mid got rd=%b busy=%b dp_raw=%h vld=%b n=%0d exp 0 1 00 0", eep_rd, cal_busy, dp_raw, out_vld, n);
    end
    @(negedge clk);
    rst = 1'b0;
    rd_addrs.delete();
    model_reset();
    ch_vld = 3'b111;
    wait_load(cyc, ack_seen);
    checks++;
    if (cal_busy !== 1'b0 || ack_seen || rd_addrs.size() != 6 || rd_addrs[0] !== 8'h00 || rd_addrs[5] !== 8'h05) begin
      failures++;
      $display("FAIL rst_reload got busy=%b ack_seen=%0d reads=%0d first=%h exp 0 0 6 00", cal_busy, ack_seen, rd_addrs.size(), rd_addrs.size() > 0 ? rd_addrs[0] : 8'hXX);
    end
    model_load(-1);
    step(3'b111, 24'h445566, 1'b0);
    checks++;
    if (o_ack !== 3'b001 || o_data !== calib(8'h66, m_off[0], m_gain[0])) begin
      failures++;
      $display("FAIL rst_first got ack=%b data=%h exp 001 %h", o_ack, o_data, calib(8'h66, m_off[0], m_gain[0]));
    end
    model_grant(0);
  endtask

  task automatic test_random();
    logic [N-1:0] held, v, exp_ack;
    logic [8*N-1:0] r;
    logic [7:0] exp_d;
    int w;
    held = '0;
    r = '0;
    for (int i = 0; i < 300; i++) begin
      v = held | (N'($urandom) & N'($urandom));
      for (int c = 0; c < N; c++)
        if (!held[c]) r[8*c +: 8] = 8'($urandom);
      w = model_pick(v);
      exp_ack = (w < 0) ? '0 : (N'(1) << w);
      exp_d = (w < 0) ? 8'h00 : calib(r[8*w +: 8], m_off[w], m_gain[w]);
      step(v, r, 1'b0);
      checks++;
      if (o_ack !== exp_ack) begin
        failures++;
        $display("FAIL rand_ack%0d got %b exp %b", i, o_ack, exp_ack);
      end
      checks++;
      if (w >= 0 && (o_vld !== 1'b1 || o_ch !== 2'(w) || o_data !== exp_d)) begin
        failures++;
        $display("FAIL rand_out%0d got vld=%b ch=%0d data=%h exp 1 %0d %h", i, o_vld, o_ch, o_data, w, exp_d);
      end else if (w < 0 && o_vld !== 1'b0) begin
        failures++;
        $display("FAIL rand_idle%0d got vld=%b exp 0", i, o_vld);
      end
      if (w >= 0) model_grant(w);
      held = v & ~exp_ack;
    end
  endtask

`ifdef CALIB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    bit ack_seen;
    for (int i = 0; i < 2*N; i++) mem[i] = 8'($urandom);
    rd_addrs.delete();
    rd_cyc.delete();
    eep_drop = 1;
    step(3'b000, 24'h0, 1'b1);
    wait_load(cyc, ack_seen);
    checks++;
    if (cal_busy !== 1'b0 || cal_err !== 1'b1 || rd_addrs.size() != 6) begin
      failures++;
      $display("FAIL tmo_done got busy=%b err=%b reads=%0d exp 0 1 6", cal_busy, cal_err, rd_addrs.size());
    end else begin
      checks++;
      if (rd_addrs[2] !== 8'h02 || rd_cyc[2] - rd_cyc[1] != 256) begin
        failures++;
        $display("FAIL tmo_gap got addr=%h gap=%0d exp 02 256", rd_addrs[2], rd_cyc[2] - rd_cyc[1]);
      end
    end
    model_load(1);
    step(3'b001, 24'h000030, 1'b0);
    checks++;
    if (o_gain !== 8'h80 || o_off !== m_off[0]) begin
      failures++;
      $display("FAIL tmo_gain0 got gain=%h off=%h exp 80 %h", o_gain, o_off, m_off[0]);
    end
    model_grant(0);
    eep_drop = -1;
    step(3'b000, 24'h0, 1'b1);
    checks++;
    if (cal_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got err=%b exp 0", cal_err);
    end
    wait_load(cyc, ack_seen);
    model_load(-1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    eep_rdy = 1'b0;
    eep_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_load();
    test_directed();
    test_rotate();
    test_cal_start();
    test_rst_mid_load();
    test_random();
`ifdef CALIB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
